// File: rtl/rr_mux.sv
// rr_mux -- N-channel streaming combiner with a one-deep registered output.
//
// Several producers offer words over valid/ready handshakes. One channel is
// granted per cycle. The grant comes from Sel in manual mode (Mode = 0), or
// from a round-robin search in Mode = 1. The granted word is captured into
// the output register whenever that register is empty or is being drained.
//
// Ports
//   Clk       rising-edge clock
//   Rst       synchronous, active-high reset
//   Mode      0 = manual select via Sel, 1 = round-robin
//   Sel       channel index used in manual mode
//   InData    channel i data at [i*WIDTH +: WIDTH]
//   InValid   per-channel data available
//   InReady   per-channel accept strobe (combinational, at most one bit set)
//   Out       registered output word
//   OutValid  Out holds a valid word
//   OutReady  consumer accepts Out
//   OutSel    index of the channel that produced Out
module rr_mux #(
   parameter int WIDTH = 8,
   parameter int N = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 Mode,
   input  logic [SELW-1:0]      Sel,
   input  logic [N*WIDTH-1:0]   InData,
   input  logic [N-1:0]         InValid,
   output logic [N-1:0]         InReady,
   output logic [WIDTH-1:0]     Out,
   output logic                 OutValid,
   input  logic                 OutReady,
   output logic [SELW-1:0]      OutSel
);

   // Last granted channel; the search starts just after it.
   logic [SELW-1:0]  ptr;
   logic             load_en;
   logic             grant_vld;
   logic [SELW-1:0]  grant_idx;
   logic [WIDTH-1:0] grant_data;

   assign load_en = !Rst && (!OutValid || OutReady);

   always_comb begin
      int c;
      grant_vld = 1'b0;
      grant_idx = '0;
      c = 0;
      if (!Mode) begin
         // A Sel value at or above N matches no channel, so nothing is granted.
         for (int i = 0; i < N; i++) begin
            if (Sel == SELW'(i) && InValid[SELW'(i)]) begin
               grant_vld = 1'b1;
               grant_idx = SELW'(i);
            end
         end
      end else begin
         // Walk ptr+1 .. ptr+N modulo N so ptr itself is checked last.
         for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!grant_vld && InValid[SELW'(c)]) begin
               grant_vld = 1'b1;
               grant_idx = SELW'(c);
            end
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_idx == SELW'(i)) begin
            grant_data = InData[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      InReady = '0;
      for (int i = 0; i < N; i++) begin
         if (load_en && grant_vld && grant_idx == SELW'(i)) begin
            InReady[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         Out      <= '0;
         OutSel   <= '0;
         OutValid <= 1'b0;
         ptr      <= SELW'(N - 1);
      end else if (load_en) begin
         if (grant_vld) begin
            Out      <= grant_data;
            OutSel   <= grant_idx;
            OutValid <= 1'b1;
            ptr      <= grant_idx;
         end else begin
            // Out and OutSel keep the last word so the bus stays quiet.
            OutValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux.sv
module tb_rr_mux;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mode = 1'b1;
   logic [1:0]  sel = '0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_valid = '0;
   logic [3:0]  in_ready;
   logic [7:0]  out;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [1:0]  out_sel;

   // Second instance with N = 3 to exercise wrap modulo N.
   logic        mode3 = 1'b1;
   logic [1:0]  sel3 = '0;
   logic [23:0] in_data3 = '0;
   logic [2:0]  in_valid3 = '0;
   logic [2:0]  in_ready3;
   logic [7:0]  out3;
   logic        out_valid3;
   logic [1:0]  out_sel3;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0]  m_out = '0;
   int          m_sel = 0;
   bit          m_vld = 0;
   int          m_ptr = 3;
   int          last_grant = -1;
   logic [7:0]  sb[$];

   always #5 clk = ~clk;

   rr_mux #(.WIDTH(8), .N(4)) u4 (
      .Clk(clk), .Rst(rst), .Mode(mode), .Sel(sel),
      .InData(in_data), .InValid(in_valid), .InReady(in_ready),
      .Out(out), .OutValid(out_valid), .OutReady(out_ready), .OutSel(out_sel)
   );

   rr_mux #(.WIDTH(8), .N(3)) u3 (
      .Clk(clk), .Rst(rst), .Mode(mode3), .Sel(sel3),
      .InData(in_data3), .InValid(in_valid3), .InReady(in_ready3),
      .Out(out3), .OutValid(out_valid3), .OutReady(1'b1), .OutSel(out_sel3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Which channel the arbitration rules pick, or -1 for none.
   function automatic int exp_grant(input bit md, input int s, input logic [3:0] v,
                                    input int p, input int n);
      if (!md) begin
         if (s < n && ((v >> s) & 4'd1) != 0) return s;
         return -1;
      end
      for (int k = 1; k <= n; k++) begin
         int c;
         c = (p + k) % n;
         if (((v >> c) & 4'd1) != 0) return c;
      end
      return -1;
   endfunction

   // One clock: check against the model at the falling edge, then advance it.
   task automatic cycle();
      int g;
      bit le;
      logic [3:0] exp_rdy;
      @(negedge clk);
      le = !rst && (!m_vld || out_ready);
      g = exp_grant(mode, int'(sel), in_valid, m_ptr, 4);
      exp_rdy = (le && g >= 0) ? 4'(1 << g) : 4'd0;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_vld));
      chk("out", 32'(out), 32'(m_out));
      chk("out_sel", 32'(out_sel), 32'(m_sel));
      if (!rst && m_vld && out_ready) begin
         chk("sb_word", 32'(out), 32'(sb.pop_front()));
      end
      last_grant = -1;
      if (rst) begin
         m_out = '0; m_sel = 0; m_vld = 0; m_ptr = 3;
         sb.delete();
      end else if (le) begin
         if (g >= 0) begin
            m_out = in_data[g*8 +: 8];
            m_sel = g; m_vld = 1; m_ptr = g;
            sb.push_back(m_out);
            last_grant = g;
         end else begin
            m_vld = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] fair_seq [4];
      fair_seq[0] = 8'h00; fair_seq[1] = 8'h11; fair_seq[2] = 8'h22; fair_seq[3] = 8'h33;

      // Reset with every channel offering data
      rst = 1'b1; in_valid = 4'b1111; in_data = 32'h33221100;
      for (int i = 0; i < 2; i++) begin
         cycle();
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out", 32'(out), 32'd0);
         chk("rst_out_sel", 32'(out_sel), 32'd0);
      end
      chk("rst_in_ready", 32'(in_ready), 32'd0);

      // Round-robin fairness
      rst = 1'b0; mode = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("fair_out", 32'(out), 32'(fair_seq[i % 4]));
         chk("fair_sel", 32'(out_sel), 32'(i % 4));
      end

      // Sparse round-robin
      in_valid = 4'b0100; cycle();
      chk("sparse_g2", 32'(out_sel), 32'd2);
      in_valid = 4'b1010; cycle();
      chk("sparse_g3", 32'(out_sel), 32'd3);
      in_valid = 4'b0010; cycle();
      chk("sparse_g1", 32'(out_sel), 32'd1);

      // Manual mode
      mode = 1'b0; sel = 2'd2; in_valid = 4'b1011; cycle();
      chk("manual_nogrant", 32'(out_valid), 32'd0);
      in_valid = 4'b1111; in_data = 32'h44A51100; cycle();
      chk("manual_out", 32'(out), 32'hA5);
      chk("manual_sel", 32'(out_sel), 32'd2);

      // Back-pressure
      mode = 1'b1; out_ready = 1'b0; in_data = 32'h7D6C5B4A;
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
         cycle();
         chk("bp_out_hold", 32'(out), 32'hA5);
      end
      out_ready = 1'b1; cycle();
      chk("bp_release_sel", 32'(out_sel), 32'd3);
      chk("bp_release_out", 32'(out), 32'h7D);

      // Mid-stream reset while stalled
      out_ready = 1'b0; cycle();
      rst = 1'b1; cycle();
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      chk("mrst_out", 32'(out), 32'd0);
      rst = 1'b0; out_ready = 1'b1; in_valid = 4'b1111; cycle();
      chk("mrst_first_grant", 32'(out_sel), 32'd0);

      // N = 3 wrap, run alongside the main instance
      in_data3 = 24'hC3B2A1;
      mode3 = 1'b1; in_valid3 = 3'b100;
      #1 chk("n3_rdy_g2", 32'(in_ready3), 32'b100);
      cycle();
      chk("n3_sel_g2", 32'(out_sel3), 32'd2);
      in_valid3 = 3'b001;
      #1 chk("n3_rdy_wrap", 32'(in_ready3), 32'b001);
      cycle();
      chk("n3_sel_wrap", 32'(out_sel3), 32'd0);
      chk("n3_out_wrap", 32'(out3), 32'hA1);
      mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
      #1 chk("n3_rdy_badsel", 32'(in_ready3), 32'd0);
      cycle();
      chk("n3_valid_badsel", 32'(out_valid3), 32'd0);
      in_valid3 = 3'b000;

      // Randomized traffic with producers that hold until accepted
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         if ($urandom_range(0, 9) == 0) sel = 2'($urandom_range(0, 3));
         for (int i = 0; i < 4; i++) begin
            if (last_grant == i) begin
               in_valid[i] = 1'($urandom_range(0, 1));
               in_data[i*8 +: 8] = 8'($urandom);
            end else if (!in_valid[i] && $urandom_range(0, 3) == 0) begin
               in_valid[i] = 1'b1;
               in_data[i*8 +: 8] = 8'($urandom);
            end
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
